// File: rtl/edge_event_arbiter.sv
// Dual-edge event detector for N level inputs; detected edges are held as one
// pending flag per channel and offered one at a time on a valid/ready port.
module edge_event_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N-1:0]     din,
   input  logic [N-1:0]     en,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [IDX_W-1:0] ev_ch,
   output logic             ev_rise,
   output logic [N-1:0]     ovf,
   input  logic             ovf_clr
);

   typedef enum logic {
      ST_IDLE,
      ST_OFFER
   } state_e;

   state_e           state_q;
   logic [N-1:0]     prev_q, pend_q, pol_q, ovf_q;
   logic [N-1:0]     pend_d, pol_d, ovf_d;
   logic [N-1:0]     edge_det, grant_oh;
   logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, ev_ch_q, grant_idx;
   logic             ev_valid_q, ev_rise_q;
   logic             grant_any, grant_fire;

   assign edge_det = (din ^ prev_q) & en;

   // Round-robin search: first pending channel at or above rr_ptr, wrapping.
   always_comb begin : rr_search
      logic [IDX_W:0]   sum;
      logic [IDX_W-1:0] idx;
      // NOTE: every variable gets a default before any branch, so no latch is inferred.
      grant_any = 1'b0;
      grant_idx = '0;
      sum       = '0;
      idx       = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N)) sum = sum - (IDX_W+1)'(N);
         idx = sum[IDX_W-1:0];
         if (!grant_any && pend_q[idx]) begin
            grant_any = 1'b1;
            grant_idx = idx;
         end
      end
   end

   // A grant happens from IDLE, or on a completed handshake while in OFFER.
   assign grant_fire = grant_any & ((state_q == ST_IDLE) | ev_ready);
   assign grant_oh   = grant_fire ? (N'(1) << grant_idx) : '0;
   assign rr_ptr_d   = (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);

   // A new edge beats the grant clear; a disabled channel drops its pending flag.
   assign pend_d = ((pend_q & ~grant_oh) | edge_det) & en;
   assign pol_d  = (pol_q & ~edge_det) | (din & edge_det);
   assign ovf_d  = (ovf_clr ? '0 : ovf_q) | (edge_det & pend_q & ~grant_oh);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         prev_q     <= '0;
         pend_q     <= '0;
         pol_q      <= '0;
         ovf_q      <= '0;
         rr_ptr_q   <= '0;
         ev_ch_q    <= '0;
         ev_rise_q  <= 1'b0;
         ev_valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         prev_q <= din;
         pend_q <= pend_d;
         pol_q  <= pol_d;
         ovf_q  <= ovf_d;
         if (grant_fire) begin
            rr_ptr_q  <= rr_ptr_d;
            ev_ch_q   <= grant_idx;
            ev_rise_q <= pol_q[grant_idx];
         end
         case (state_q)
            ST_IDLE: begin
               if (grant_fire) begin
                  state_q    <= ST_OFFER;
                  ev_valid_q <= 1'b1;
               end
            end
            ST_OFFER: begin
               if (ev_ready && !grant_fire) begin
                  state_q    <= ST_IDLE;
                  ev_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               ev_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_ch    = ev_ch_q;
   assign ev_rise  = ev_rise_q;
   assign ovf      = ovf_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed bench for edge_event_arbiter (N=4): round-robin order, single edge,
// stall/overflow, grant collision, masking and asynchronous reset.
module tb_edge_event_arbiter;

   localparam int N     = 4;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     din;
   logic [N-1:0]     en;
   logic             ev_valid;
   logic             ev_ready;
   logic [IDX_W-1:0] ev_ch;
   logic             ev_rise;
   logic [N-1:0]     ovf;
   logic             ovf_clr;

   int total = 0;
   int bad   = 0;

   edge_event_arbiter #(.N(N), .IDX_W(IDX_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .din      (din),
      .en       (en),
      .ev_valid (ev_valid),
      .ev_ready (ev_ready),
      .ev_ch    (ev_ch),
      .ev_rise  (ev_rise),
      .ovf      (ovf),
      .ovf_clr  (ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_ev(input string tag, input int ch, input logic rise);
      check({tag, ".valid"}, 32'(ev_valid), 32'd1);
      check({tag, ".ch"},    32'(ev_ch),    32'(ch));
      check({tag, ".rise"},  32'(ev_rise),  32'(rise));
   endtask

   task automatic expect_idle(input string tag);
      check({tag, ".valid"}, 32'(ev_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst      = 1'b0;
      din      = '0;
      en       = '0;
      ev_ready = 1'b0;
      ovf_clr  = 1'b0;
      repeat (2) tick();
      check("rst.valid", 32'(ev_valid), 32'd0);
      check("rst.ch",    32'(ev_ch),    32'd0);
      check("rst.rise",  32'(ev_rise),  32'd0);
      check("rst.ovf",   32'(ovf),      32'd0);
      rst      = 1'b1;
      en       = 4'hF;
      ev_ready = 1'b1;

      // Round robin from rr_ptr=0: all four rise together.
      din = 4'hF;
      tick(); expect_idle("rr1.lat");
      tick(); expect_ev("rr1.e0", 0, 1'b1);
      tick(); expect_ev("rr1.e1", 1, 1'b1);
      tick(); expect_ev("rr1.e2", 2, 1'b1);
      tick(); expect_ev("rr1.e3", 3, 1'b1);
      tick(); expect_idle("rr1.end");

      // Grant channel 1 alone so rr_ptr becomes 2.
      din = 4'b1101;
      tick();
      tick(); expect_ev("pre.e1", 1, 1'b0);
      tick(); expect_idle("pre.end");

      // All four toggle: bits 0,2,3 fall, bit 1 rises; order 2,3,0,1.
      din = 4'b0010;
      tick();
      tick(); expect_ev("rr2.e2", 2, 1'b0);
      tick(); expect_ev("rr2.e3", 3, 1'b0);
      tick(); expect_ev("rr2.e0", 0, 1'b0);
      tick(); expect_ev("rr2.e1", 1, 1'b1);
      tick(); expect_idle("rr2.end");

      // Single edge on channel 2, both polarities, one-cycle offers.
      din = 4'b0110;
      tick(); expect_idle("one.lat");
      tick(); expect_ev("one.rise", 2, 1'b1);
      tick(); expect_idle("one.gap");
      din = 4'b0010;
      tick();
      tick(); expect_ev("one.fall", 2, 1'b0);
      tick(); expect_idle("one.end");

      // Bring channel 1 low (rr_ptr=3 -> grant 1, rr_ptr=2).
      din = 4'b0000;
      tick();
      tick(); expect_ev("ch1lo", 1, 1'b0);
      tick(); expect_idle("ch1lo.end");

      // Stall on channel 0, then channel 1 toggles 0->1->0 twice while pending.
      ev_ready = 1'b0;
      din = 4'b0001;
      tick();
      tick(); expect_ev("stall.e0", 0, 1'b1);
      din = 4'b0011;
      tick(); check("stall.ovf_a", 32'(ovf), 32'h0);
      din = 4'b0001;
      tick(); check("stall.ovf_b", 32'(ovf), 32'h2);
      expect_ev("stall.hold", 0, 1'b1);
      ev_ready = 1'b1;
      tick(); expect_ev("stall.e1", 1, 1'b0);
      tick(); expect_idle("stall.end");
      check("stall.ovf_kept", 32'(ovf), 32'h2);
      ovf_clr = 1'b1;
      tick(); ovf_clr = 1'b0;
      check("ovf_clr", 32'(ovf), 32'h0);

      // Collision: channel 3 falls on the edge it is granted (rr_ptr=2).
      din = 4'b1001;
      tick();
      din = 4'b0001;
      tick(); expect_ev("col.e3a", 3, 1'b1);
      check("col.ovf_a", 32'(ovf), 32'h0);
      tick(); expect_ev("col.e3b", 3, 1'b0);
      tick(); expect_idle("col.end");
      check("col.ovf_b", 32'(ovf), 32'h0);

      // Masking: stall on channel 1, set pend[0], then disable channel 0.
      ev_ready = 1'b0;
      din = 4'b0011;
      tick();
      tick(); expect_ev("msk.e1", 1, 1'b1);
      din = 4'b0010;
      tick();
      en = 4'b1110;
      tick();
      din = 4'b0011;
      tick();
      ev_ready = 1'b1;
      tick(); expect_idle("msk.drop");
      tick(); expect_idle("msk.none");
      en  = 4'hF;
      din = 4'b0010;
      tick();
      tick(); expect_ev("msk.reen", 0, 1'b0);
      tick(); expect_idle("msk.end");

      // Asynchronous reset in the middle of an offer with an overflow flagged.
      ev_ready = 1'b0;
      din = 4'b0011;
      tick();
      tick(); expect_ev("ar.e0", 0, 1'b1);
      din = 4'b0001;
      tick();
      din = 4'b0011;
      tick(); check("ar.ovf_pre", 32'(ovf), 32'h2);
      #2;
      rst = 1'b0;
      din = 4'b0000;
      #1;
      check("ar.valid", 32'(ev_valid), 32'd0);
      check("ar.ovf",   32'(ovf),      32'h0);
      check("ar.rise",  32'(ev_rise),  32'd0);
      tick();
      #2 rst = 1'b1;
      ev_ready = 1'b1;
      tick(); expect_idle("ar.post1");
      tick(); expect_idle("ar.post2");
      tick(); expect_idle("ar.post3");
      check("ar.ovf_post", 32'(ovf), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/edge_event_arbiter.md
# edge_event_arbiter

Multi-channel dual-edge event scheduler. It watches N single-bit synchronous inputs and detects both rising and falling edges on each. Detected events are queued as one pending flag per channel and shared onto a single valid/ready event port by a round-robin arbiter. It sits between a bank of level signals and one downstream consumer that handles one edge event at a time, such as an interrupt or logging unit.

## Interface
- N, default 4: number of input channels, 2..16.
- IDX_W, default $clog2(N): width of the channel index.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- din  in  N  level inputs. Already synchronous to clk; no synchronizer inside.
- en  in  N  per-channel enable. 0 ignores edges on that channel and drops its pending event.
- ev_valid  out  1  event offered.
- ev_ready  in  1  consumer accepts the offered event.
- ev_ch  out  IDX_W  channel of the offered event.
- ev_rise  out  1  1 = rising edge, 0 = falling edge.
- ovf  out  N  sticky per-channel overflow flags.
- ovf_clr  in  1  synchronous pulse that clears all ovf bits.

## Operation
- Per channel i:
  - prev_q[i] <= din[i] every cycle.
  - edge[i] = (din[i] != prev_q[i]) & en[i].
- Pending set: on edge[i], pend[i] <= 1 and pol[i] <= din[i].
- Overflow: edge[i] while pend[i]=1 and i is not granted on the same edge.
  - ovf[i] <= 1.
  - pol[i] is overwritten with the newest polarity.
  - pend[i] stays 1. Only the latest polarity is reported.
- Grant/set collision: if channel i is granted and edge[i] occurs on the same clock edge, pend[i] stays 1 (set wins). This is not an overflow.
- Masking: en[i]=0 clears pend[i] at the next edge. ovf[i] is unaffected.
- Arbiter FSM has two states:
  - IDLE: ev_valid=0. If any pend bit is set, grant and go to OFFER.
  - OFFER: ev_valid=1; ev_ch and ev_rise are held stable until the handshake.
    - On ev_valid & ev_ready: if any pend bit is set (excluding the one just cleared), grant again and stay in OFFER (back-to-back). Otherwise go to IDLE.
- Grant action, all at one clock edge:
  - Pick the first set pend bit searching from rr_ptr upward, wrapping modulo N.
  - Load ev_ch and ev_rise <= pol[g].
  - Clear pend[g]; set rr_ptr <= (g+1) mod N.
- rr_ptr wraps from N-1 to 0.
- ovf_clr clears all ovf bits. A simultaneous new overflow on channel i leaves ovf[i]=1 (set wins).

## Timing
- Reset (rst=0, asynchronous):
  - ev_valid=0, ev_ch=0, ev_rise=0, ovf=0.
  - pend=0, pol=0, prev_q=0, rr_ptr=0, FSM=IDLE.
- After reset release, a din bit already high produces a rising event on the first clk edge. Hold en low to suppress it.
- Latency: din change sampled at edge k sets pend at edge k. Grant occurs at edge k+1, so ev_valid is high after k+1. Minimum latency is 2 edges when idle.
- Throughput: one event per cycle with ev_ready held high; no bubble between grants.
- Stall: with ev_valid=1 and ev_ready=0, the outputs hold indefinitely. Pending flags keep accumulating, and overflow can occur.
- Reset asserted mid-offer drops the offered event and all pending state immediately.

## Test plan
- Single edge, N=4, en=4'hF, ev_ready=1: din[2] 0->1 at edge 5 -> ev_valid=1, ev_ch=2, ev_rise=1 after edge 6 for exactly one cycle. Then din[2] 1->0 -> ev_rise=0.
- Round-robin fairness: din 4'h0->4'hF in one cycle, ev_ready=1 -> four consecutive events with ev_ch 0,1,2,3 and no gaps. Repeat with rr_ptr=2 (after a prior grant of channel 1) -> order 2,3,0,1.
- Stall and overflow: ev_ready=0 while channel 1 toggles 0->1->0 on consecutive cycles -> ovf[1]=1 and a single event later with ev_rise=0. ovf_clr pulse -> ovf=0.
- Collision: channel 3 toggles on the exact edge it is granted -> ev_ch=3 now and ev_ch=3 again on the next grant, with ovf[3]=0.
- Masking: set en[0]=0 with pend[0] set; toggle din[0] -> no event for channel 0. Re-enable -> the next toggle is reported.
- Async reset: assert rst low mid-OFFER between clock edges -> ev_valid and ovf drop to 0 immediately, and no event appears after release while din is held at 0.
